shutdown_force: RTL and testbench

SHUTDOWN_FORCE -- requirements
Module: shutdown_force

---
 rtl/shutdown_force.sv | 149 ++++++++++++++
 tb/tb_shutdown_force.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/shutdown_force.sv
`default_nettype none
// ============================================================================
// Module   : shutdown_force
// Function : Serialises an 8-bit shutdown-force word into an external 8-bit
//            addressable latch, one channel per setup/strobe/hold slot.
// Revision : 1.0 - initial release
// ============================================================================
module shutdown_force #(
    parameter int SETUP_CYCLES  = 2,
    parameter int STROBE_CYCLES = 4,
    parameter int HOLD_CYCLES   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] force_req,
    input  logic       force_req_valid,
    output logic       force_req_ready,
    output logic [2:0] shutdown_force_sel,
    output logic       shutdown_force_data,
    output logic       shutdown_force_le_n,
    output logic [7:0] shutdown_force_applied,
    output logic       busy
);

    localparam logic [7:0] c_SETUP_LAST  = 8'(SETUP_CYCLES - 1);
    localparam logic [7:0] c_STROBE_LAST = 8'(STROBE_CYCLES - 1);
    localparam logic [7:0] c_HOLD_LAST   = 8'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_INIT_SETUP  = 3'd0,
        ST_INIT_STROBE = 3'd1,
        ST_INIT_HOLD   = 3'd2,
        ST_IDLE        = 3'd3,
        ST_SETUP       = 3'd4,
        ST_STROBE      = 3'd5,
        ST_HOLD        = 3'd6
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] chan_q, chan_d;
    logic [7:0] phase_q, phase_d;
    logic [7:0] word_q, word_d;
    logic [7:0] applied_q, applied_d;
    logic [2:0] sel_q, sel_d;
    logic       data_q, data_d;

    logic       w_in_init;
    logic [2:0] w_chan_next;
    logic [7:0] w_phase_inc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_INIT_SETUP;
            chan_q    <= 3'd0;
            phase_q   <= 8'd0;
            word_q    <= 8'd0;
            applied_q <= 8'd0;
            sel_q     <= 3'd0;
            data_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            chan_q    <= chan_d;
            phase_q   <= phase_d;
            word_q    <= word_d;
            applied_q <= applied_d;
            sel_q     <= sel_d;
            data_q    <= data_d;
        end
    end

    assign w_in_init   = (state_q == ST_INIT_SETUP) || (state_q == ST_INIT_STROBE) ||
                         (state_q == ST_INIT_HOLD);
    assign w_chan_next = chan_q + 3'd1;
    assign w_phase_inc = phase_q + 8'd1;

    always_comb begin
        state_d   = state_q;
        chan_d    = chan_q;
        phase_d   = phase_q;
        word_d    = word_q;
        applied_d = applied_q;
        sel_d     = sel_q;
        data_d    = data_q;

        case (state_q)
            ST_INIT_SETUP, ST_SETUP: begin
                if (phase_q == c_SETUP_LAST) begin
                    phase_d = 8'd0;
                    state_d = w_in_init ? ST_INIT_STROBE : ST_STROBE;
                end else begin
                    phase_d = w_phase_inc;
                end
            end
            ST_INIT_STROBE, ST_STROBE: begin
                if (phase_q == c_STROBE_LAST) begin
                    phase_d = 8'd0;
                    state_d = w_in_init ? ST_INIT_HOLD : ST_HOLD;
                end else begin
                    phase_d = w_phase_inc;
                end
            end
            ST_INIT_HOLD, ST_HOLD: begin
                if (phase_q == c_HOLD_LAST) begin
                    phase_d = 8'd0;
                    if (chan_q == 3'd7) begin
                        // Pass complete: publish the word; sel/data stay on channel 7.
                        state_d   = ST_IDLE;
                        applied_d = w_in_init ? 8'd0 : word_q;
                    end else begin
                        // sel/data only move here, while le_n is high.
                        state_d = w_in_init ? ST_INIT_SETUP : ST_SETUP;
                        chan_d  = w_chan_next;
                        sel_d   = w_chan_next;
                        data_d  = w_in_init ? 1'b0 : word_q[w_chan_next];
                    end
                end else begin
                    phase_d = w_phase_inc;
                end
            end
            ST_IDLE: begin
                if (force_req_valid) begin
                    state_d = ST_SETUP;
                    word_d  = force_req;
                    chan_d  = 3'd0;
                    phase_d = 8'd0;
                    sel_d   = 3'd0;
                    data_d  = force_req[0];
                end
            end
            default: begin
                state_d = ST_INIT_SETUP;
                chan_d  = 3'd0;
                phase_d = 8'd0;
                word_d  = 8'd0;
                sel_d   = 3'd0;
                data_d  = 1'b0;
            end
        endcase
    end

    assign force_req_ready        = (state_q == ST_IDLE);
    assign busy                   = ~force_req_ready;
    assign shutdown_force_sel     = sel_q;
    assign shutdown_force_data    = data_q;
    assign shutdown_force_le_n    = ~((state_q == ST_STROBE) || (state_q == ST_INIT_STROBE));
    assign shutdown_force_applied = applied_q;

endmodule
`default_nettype wire

// File: tb/tb_shutdown_force.sv
`default_nettype none
// ============================================================================
// Module   : tb_shutdown_force
// Function : Self-checking bench for shutdown_force (default and 1/1/1 timing).
// Revision : 1.0 - initial release
// ============================================================================
module tb_shutdown_force;

    localparam int c_S = 2;
    localparam int c_T = 4;
    localparam int c_H = 2;

    typedef struct packed {
        logic [2:0] sel;
        logic       data;
        logic       le_n;
        logic       ready;
        logic       busy;
        logic [7:0] applied;
    } obs_t;

    typedef struct {
        logic [7:0] word;
        logic [7:0] exp_applied;
        logic       exp_last_data;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] force_req;
    logic       valid;
    logic       ready, le_n, data, busy;
    logic [2:0] sel;
    logic [7:0] applied;

    logic [7:0] f_req;
    logic       f_valid;
    logic       f_ready, f_le_n, f_data, f_busy;
    logic [2:0] f_sel;
    logic [7:0] f_applied;

    int   checks = 0;
    int   errors = 0;
    obs_t sb[$];
    logic [7:0] model_applied;
    vec_t vecs[8];

    always #5 clk = ~clk;

    shutdown_force u_dut (
        .clk                    (clk),
        .rst                    (rst),
        .force_req              (force_req),
        .force_req_valid        (valid),
        .force_req_ready        (ready),
        .shutdown_force_sel     (sel),
        .shutdown_force_data    (data),
        .shutdown_force_le_n    (le_n),
        .shutdown_force_applied (applied),
        .busy                   (busy)
    );

    shutdown_force #(
        .SETUP_CYCLES  (1),
        .STROBE_CYCLES (1),
        .HOLD_CYCLES   (1)
    ) u_fast (
        .clk                    (clk),
        .rst                    (rst),
        .force_req              (f_req),
        .force_req_valid        (f_valid),
        .force_req_ready        (f_ready),
        .shutdown_force_sel     (f_sel),
        .shutdown_force_data    (f_data),
        .shutdown_force_le_n    (f_le_n),
        .shutdown_force_applied (f_applied),
        .busy                   (f_busy)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic obs_t obs_now();
        obs_t o;
        o.sel = sel; o.data = data; o.le_n = le_n;
        o.ready = ready; o.busy = busy; o.applied = applied;
        return o;
    endfunction

    // Advance one cycle; sel/data must not move while the latch is enabled.
    task automatic tick();
        logic [3:0] pm, pf;
        pm = {sel, data};
        pf = {f_sel, f_data};
        @(posedge clk);
        #1;
        if (le_n === 1'b0)   chk("le_n_low_sel_data_stable", 32'({sel, data}), 32'(pm));
        if (f_le_n === 1'b0) chk("fast_le_n_low_sel_data_stable", 32'({f_sel, f_data}), 32'(pf));
    endtask

    task automatic push_pass(input logic [7:0] w, input logic init, input logic [7:0] app_before);
        obs_t o;
        for (int ch = 0; ch < 8; ch++) begin
            for (int c = 0; c < c_S + c_T + c_H; c++) begin
                o.sel     = 3'(ch);
                o.data    = init ? 1'b0 : w[ch];
                o.le_n    = !(c >= c_S && c < c_S + c_T);
                o.ready   = 1'b0;
                o.busy    = 1'b1;
                o.applied = app_before;
                sb.push_back(o);
            end
        end
    endtask

    task automatic drain(input int n, input logic chg, input int chg_at, input logic [7:0] chg_val);
        obs_t e;
        for (int i = 0; i < n; i++) begin
            if (sb.size() == 0) break;
            e = sb.pop_front();
            if (chg && i == chg_at) force_req = chg_val;
            chk($sformatf("pass_cycle_%0d", i), 32'(obs_now()), 32'(e));
            tick();
        end
    endtask

    task automatic check_idle(input string name, input logic [7:0] exp_app, input logic exp_last);
        obs_t e;
        e.sel = 3'd7; e.data = exp_last; e.le_n = 1'b1;
        e.ready = 1'b1; e.busy = 1'b0; e.applied = exp_app;
        chk(name, 32'(obs_now()), 32'(e));
    endtask

    task automatic check_reset_state(input string name);
        obs_t e;
        e.sel = 3'd0; e.data = 1'b0; e.le_n = 1'b1;
        e.ready = 1'b0; e.busy = 1'b1; e.applied = 8'h00;
        chk(name, 32'(obs_now()), 32'(e));
    endtask

    task automatic send(input logic [7:0] w);
        chk("ready_before_send", 32'(ready), 32'd1);
        force_req = w;
        valid     = 1'b1;
        tick();
        valid     = 1'b0;
        force_req = ~w;
        push_pass(w, 1'b0, model_applied);
        drain(sb.size(), 1'b0, 0, 8'h00);
        model_applied = w;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cyc, lows, hi_strobe;

        vecs[0] = '{8'hA5, 8'hA5, 1'b1};
        vecs[1] = '{8'h00, 8'h00, 1'b0};
        vecs[2] = '{8'hFF, 8'hFF, 1'b1};
        vecs[3] = '{8'h5A, 8'h5A, 1'b0};
        vecs[4] = '{8'h80, 8'h80, 1'b1};
        vecs[5] = '{8'h80, 8'h80, 1'b1};
        vecs[6] = '{8'h3C, 8'h3C, 1'b0};
        vecs[7] = '{8'h01, 8'h01, 1'b0};

        rst = 1'b1; valid = 1'b0; force_req = 8'h00;
        f_valid = 1'b0; f_req = 8'h00;
        model_applied = 8'h00;

        // Reset, then the init pass must take exactly 64 cycles.
        tick();
        tick();
        check_reset_state("reset_state");
        rst = 1'b0;
        push_pass(8'h00, 1'b1, 8'h00);
        drain(sb.size(), 1'b0, 0, 8'h00);
        check_idle("init_pass_done", 8'h00, 1'b0);

        for (int i = 0; i < 8; i++) begin
            send(vecs[i].word);
            check_idle($sformatf("vec%0d_idle", i), vecs[i].exp_applied, vecs[i].exp_last_data);
        end

        // Valid held through a pass while the word changes: only the value at the ready edge is taken.
        force_req = 8'hFF; valid = 1'b1;
        tick();
        push_pass(8'hFF, 1'b0, model_applied);
        drain(sb.size(), 1'b1, 10, 8'h0F);
        model_applied = 8'hFF;
        check_idle("held_valid_first_word", 8'hFF, 1'b1);
        tick();
        valid = 1'b0;
        push_pass(8'h0F, 1'b0, model_applied);
        drain(sb.size(), 1'b0, 0, 8'h00);
        model_applied = 8'h0F;
        check_idle("held_valid_second_word", 8'h0F, 1'b0);

        // Back-to-back: second word accepted in the first IDLE cycle.
        force_req = 8'h01; valid = 1'b1;
        tick();
        force_req = 8'h02;
        push_pass(8'h01, 1'b0, model_applied);
        drain(sb.size(), 1'b0, 0, 8'h00);
        model_applied = 8'h01;
        check_idle("b2b_first", 8'h01, 1'b0);
        tick();
        valid = 1'b0;
        push_pass(8'h02, 1'b0, model_applied);
        drain(sb.size(), 1'b0, 0, 8'h00);
        model_applied = 8'h02;
        check_idle("b2b_second", 8'h02, 1'b0);

        // Reset during channel 3 strobe aborts the pass.
        force_req = 8'hFF; valid = 1'b1;
        tick();
        valid = 1'b0;
        push_pass(8'hFF, 1'b0, model_applied);
        drain(3 * (c_S + c_T + c_H) + c_S, 1'b0, 0, 8'h00);
        chk("abort_in_ch3_strobe", 32'({sel, le_n}), 32'({3'd3, 1'b0}));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        model_applied = 8'h00;
        check_reset_state("abort_reset_state");
        push_pass(8'h00, 1'b1, 8'h00);
        drain(sb.size(), 1'b0, 0, 8'h00);
        check_idle("abort_init_done", 8'h00, 1'b0);

        // Fast instance: 1/1/1 timing gives a 24-cycle pass.
        chk("fast_idle_ready", 32'({f_ready, f_applied}), 32'({1'b1, 8'h00}));
        f_req = 8'h81; f_valid = 1'b1;
        tick();
        f_valid = 1'b0;
        cyc = 0; lows = 0; hi_strobe = 0;
        while (!f_ready && cyc < 200) begin
            if (!f_le_n) begin
                lows++;
                if (f_data) hi_strobe++;
            end
            tick();
            cyc++;
        end
        chk("fast_pass_cycles", 32'(cyc), 32'd24);
        chk("fast_strobe_count", 32'(lows), 32'd8);
        chk("fast_strobes_with_data1", 32'(hi_strobe), 32'd2);
        chk("fast_applied", 32'({f_applied, f_sel, f_data, f_le_n, f_busy}),
            32'({8'h81, 3'd7, 1'b1, 1'b1, 1'b0}));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
